// File: rtl/mem_req_arbiter_if.sv
// Signal bundle for the memory request arbiter: per-client request and
// response lanes plus the single shared memory port they are funnelled onto.
interface mem_req_arbiter_if #(
    parameter int CLIENT_CNT = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [CLIENT_CNT-1:0]            cl_req_valid;
    logic [CLIENT_CNT-1:0]            cl_req_write;
    logic [CLIENT_CNT*ADDR_WIDTH-1:0] cl_req_addr;
    logic [CLIENT_CNT*2-1:0]          cl_req_size;
    logic [CLIENT_CNT*DATA_WIDTH-1:0] cl_req_data;
    logic [CLIENT_CNT-1:0]            cl_rsp_done;
    logic [CLIENT_CNT-1:0]            cl_rsp_err;
    logic [DATA_WIDTH-1:0]            cl_rsp_data;

    logic                             mem_req_valid;
    logic                             mem_req_write;
    logic [ADDR_WIDTH-1:0]            mem_req_addr;
    logic [1:0]                       mem_req_size;
    logic [DATA_WIDTH-1:0]            mem_req_data;
    logic                             mem_rsp_done;
    logic [DATA_WIDTH-1:0]            mem_rsp_data;

    // The arbiter: answers the clients and masters the shared memory port.
    modport master (
        input  cl_req_valid, cl_req_write, cl_req_addr, cl_req_size, cl_req_data,
        output cl_rsp_done, cl_rsp_err, cl_rsp_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_data,
        input  mem_rsp_done, mem_rsp_data
    );

    // The surroundings: requesting clients and the memory that serves them.
    modport slave (
        output cl_req_valid, cl_req_write, cl_req_addr, cl_req_size, cl_req_data,
        input  cl_rsp_done, cl_rsp_err, cl_rsp_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_data,
        output mem_rsp_done, mem_rsp_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter multiplexing CLIENT_CNT memory requesters onto one
// memory port. Misaligned requests are answered with an error without touching
// memory; a silent memory is answered with an error after TIMEOUT_CYCLES.
module mem_req_arbiter #(
    parameter int CLIENT_CNT     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst_n,
    mem_req_arbiter_if.master bus
);
    localparam int IDX_W = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CLIENT_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rrPtr_q, rrPtr_d;
    logic [CLIENT_CNT-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]        tmoCnt_q, tmoCnt_d;

    logic                    memValid_q, memValid_d;
    logic                    memWrite_q, memWrite_d;
    logic [ADDR_WIDTH-1:0]   memAddr_q, memAddr_d;
    logic [1:0]              memSize_q, memSize_d;
    logic [DATA_WIDTH-1:0]   memData_q, memData_d;

    logic [CLIENT_CNT-1:0]   rspDone_q, rspDone_d;
    logic [CLIENT_CNT-1:0]   rspErr_q, rspErr_d;
    logic [DATA_WIDTH-1:0]   rspData_q, rspData_d;

    logic                    anyValid;
    logic [CLIENT_CNT-1:0]   pickOh;
    logic [IDX_W-1:0]        pickIdx;
    logic                    pickWrite;
    logic [ADDR_WIDTH-1:0]   pickAddr;
    logic [1:0]              pickSize;
    logic [DATA_WIDTH-1:0]   pickData;
    logic                    pickMisaligned;
    logic                    timeoutHit;

    // Size 3 is reserved; halfwords need an even address, words a 4-byte one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd1:    bad = addrLo[0];
            2'd2:    bad = (addrLo != 2'b00);
            2'd3:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Round-robin search: first valid client at or above rrPtr, else the first below it.
    always_comb begin
        anyValid = 1'b0;
        pickOh   = '0;
        pickIdx  = '0;
        for (int i = 0; i < CLIENT_CNT; i++) begin
            if (!anyValid && bus.cl_req_valid[i] && (i >= int'(rrPtr_q))) begin
                anyValid  = 1'b1;
                pickOh[i] = 1'b1;
                pickIdx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < CLIENT_CNT; i++) begin
            if (!anyValid && bus.cl_req_valid[i]) begin
                anyValid  = 1'b1;
                pickOh[i] = 1'b1;
                pickIdx   = IDX_W'(i);
            end
        end
    end

    // Select the request fields of the client picked by the search.
    always_comb begin
        pickWrite = 1'b0;
        pickAddr  = '0;
        pickSize  = '0;
        pickData  = '0;
        for (int i = 0; i < CLIENT_CNT; i++) begin
            if (pickOh[i]) begin
                pickWrite = bus.cl_req_write[i];
                pickAddr  = bus.cl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pickSize  = bus.cl_req_size[i*2 +: 2];
                pickData  = bus.cl_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign pickMisaligned = misaligned(pickSize, pickAddr[1:0]);
    assign timeoutHit     = (TIMEOUT_CYCLES != 0) && ((tmoCnt_q + CNT_W'(1)) == TMO_LIMIT);

    // Next-state and next-output logic; responses default to a quiet bus each cycle.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        grant_d    = grant_q;
        tmoCnt_d   = tmoCnt_q;
        memValid_d = memValid_q;
        memWrite_d = memWrite_q;
        memAddr_d  = memAddr_q;
        memSize_d  = memSize_q;
        memData_d  = memData_q;
        rspDone_d  = '0;
        rspErr_d   = '0;
        rspData_d  = '0;

        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    grant_d  = pickOh;
                    rrPtr_d  = (pickIdx == LAST_IDX) ? '0 : pickIdx + IDX_W'(1);
                    tmoCnt_d = '0;
                    if (pickMisaligned) begin
                        state_d = RESP;
                    end else begin
                        state_d    = BUSY;
                        memValid_d = 1'b1;
                        memWrite_d = pickWrite;
                        memAddr_d  = pickAddr;
                        memSize_d  = pickSize;
                        memData_d  = pickWrite ? pickData : '0;
                    end
                end
            end

            BUSY: begin
                tmoCnt_d = tmoCnt_q + CNT_W'(1);
                if (bus.mem_rsp_done || timeoutHit) begin
                    state_d    = RESP;
                    rspDone_d  = grant_q;
                    memValid_d = 1'b0;
                    memWrite_d = 1'b0;
                    memAddr_d  = '0;
                    memSize_d  = '0;
                    memData_d  = '0;
                    if (bus.mem_rsp_done) begin
                        rspData_d = memWrite_q ? '0 : bus.mem_rsp_data;
                    end else begin
                        rspErr_d = grant_q;
                    end
                end
            end

            RESP: begin
                // A misaligned request arrives here with no response issued yet.
                if (rspDone_q == '0) begin
                    rspDone_d = grant_q;
                    rspErr_d  = grant_q;
                end else begin
                    state_d  = IDLE;
                    tmoCnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grant_q    <= '0;
            tmoCnt_q   <= '0;
            memValid_q <= 1'b0;
            memWrite_q <= 1'b0;
            memAddr_q  <= '0;
            memSize_q  <= '0;
            memData_q  <= '0;
            rspDone_q  <= '0;
            rspErr_q   <= '0;
            rspData_q  <= '0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            grant_q    <= grant_d;
            tmoCnt_q   <= tmoCnt_d;
            memValid_q <= memValid_d;
            memWrite_q <= memWrite_d;
            memAddr_q  <= memAddr_d;
            memSize_q  <= memSize_d;
            memData_q  <= memData_d;
            rspDone_q  <= rspDone_d;
            rspErr_q   <= rspErr_d;
            rspData_q  <= rspData_d;
        end
    end

    assign bus.mem_req_valid = memValid_q;
    assign bus.mem_req_write = memWrite_q;
    assign bus.mem_req_addr  = memAddr_q;
    assign bus.mem_req_size  = memSize_q;
    assign bus.mem_req_data  = memData_q;
    assign bus.cl_rsp_done   = rspDone_q;
    assign bus.cl_rsp_err    = rspErr_q;
    assign bus.cl_rsp_data   = rspData_q;
endmodule
